// File: rtl/wb_queue.sv
// Writeback queue between the LSU/ALU result ports and the register bank's single write port.
// Results are buffered in program order, drained one per cycle, and exposed to decode via a youngest-match lookup.
module wb_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       l_valid,
    input  logic [4:0]                 l_rd,
    input  logic [XLEN-1:0]            l_data,
    input  logic                       a_valid,
    input  logic [4:0]                 a_rd,
    input  logic [XLEN-1:0]            a_data,
    output logic                       in_ready,
    output logic [4:0]                 a3,
    output logic [XLEN-1:0]            wd3,
    output logic                       we,
    input  logic [4:0]                 q_a1,
    input  logic [4:0]                 q_a2,
    output logic                       q_hit1,
    output logic                       q_hit2,
    output logic [XLEN-1:0]            q_data1,
    output logic [XLEN-1:0]            q_data2,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]      r_rd   [DEPTH];
    logic [XLEN-1:0] r_data [DEPTH];
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [CW-1:0]   r_count;

    logic            w_pop;
    logic            w_l_push;
    logic            w_a_push;
    logic [1:0]      w_n_push;
    logic [PW-1:0]   w_a_slot;
    logic [PW-1:0]   w_idx;

    assign in_ready = (CW'(DEPTH) - r_count) >= CW'(2);
    assign w_pop    = (r_count != '0);
    // x0 results are accepted from the producer but never occupy a slot
    assign w_l_push = l_valid && in_ready && (l_rd != 5'd0);
    assign w_a_push = a_valid && in_ready && (a_rd != 5'd0);
    assign w_n_push = {1'b0, w_l_push} + {1'b0, w_a_push};
    assign w_a_slot = r_tail + PW'(w_l_push);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_rd[i]   <= '0;
                r_data[i] <= '0;
            end
        end else begin
            if (w_l_push) begin
                r_rd[r_tail]   <= l_rd;
                r_data[r_tail] <= l_data;
            end
            if (w_a_push) begin
                r_rd[w_a_slot]   <= a_rd;
                r_data[w_a_slot] <= a_data;
            end
            r_tail  <= r_tail + PW'(w_n_push);
            r_head  <= r_head + PW'(w_pop);
            r_count <= r_count + CW'(w_n_push) - CW'(w_pop);
        end
    end

    assign count = r_count;
    assign we    = w_pop;
    assign a3    = w_pop ? r_rd[r_head]   : 5'd0;
    assign wd3   = w_pop ? r_data[r_head] : '0;

    // Walk from head toward tail so later matches (younger entries) overwrite earlier ones
    always_comb begin
        q_hit1  = 1'b0;
        q_hit2  = 1'b0;
        q_data1 = '0;
        q_data2 = '0;
        w_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_head + PW'(i);
            if (CW'(i) < r_count) begin
                if ((q_a1 != 5'd0) && (r_rd[w_idx] == q_a1)) begin
                    q_hit1  = 1'b1;
                    q_data1 = r_data[w_idx];
                end
                if ((q_a2 != 5'd0) && (r_rd[w_idx] == q_a2)) begin
                    q_hit2  = 1'b1;
                    q_data2 = r_data[w_idx];
                end
            end
        end
    end
endmodule

// File: tb/tb_wb_queue.sv
// Bench for wb_queue: a scoreboard queue of accepted entries predicts every bank write, occupancy and lookup.
module tb_wb_queue;
    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            l_valid = 1'b0, a_valid = 1'b0;
    logic [4:0]      l_rd = '0, a_rd = '0, q_a1 = '0, q_a2 = '0;
    logic [XLEN-1:0] l_data = '0, a_data = '0;
    logic            in_ready, we, q_hit1, q_hit2;
    logic [4:0]      a3;
    logic [XLEN-1:0] wd3, q_data1, q_data2;
    logic [CW-1:0]   count;

    wb_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .l_valid(l_valid), .l_rd(l_rd), .l_data(l_data),
        .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data),
        .in_ready(in_ready), .a3(a3), .wd3(wd3), .we(we),
        .q_a1(q_a1), .q_a2(q_a2), .q_hit1(q_hit1), .q_hit2(q_hit2),
        .q_data1(q_data1), .q_data2(q_data2), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } ent_t;

    typedef struct {
        bit              lv;
        logic [4:0]      lrd;
        logic [XLEN-1:0] ld;
        bit              av;
        logic [4:0]      ard;
        logic [XLEN-1:0] ad;
        logic [4:0]      qa1;
        logic [4:0]      qa2;
    } vec_t;

    ent_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void mlook(input logic [4:0] a, output logic hit, output logic [XLEN-1:0] d);
        hit = 1'b0;
        d   = '0;
        if (a != 5'd0)
            foreach (sb[i])
                if (sb[i].rd == a) begin
                    hit = 1'b1;
                    d   = sb[i].data;
                end
    endfunction

    task automatic check_outputs();
        logic            h;
        logic [XLEN-1:0] d;
        chk("count", 32'(count), sb.size());
        chk("in_ready", 32'(in_ready), 32'((DEPTH - sb.size()) >= 2));
        if (sb.size() > 0) begin
            chk("we", 32'(we), 1);
            chk("a3", 32'(a3), 32'(sb[0].rd));
            chk("wd3", wd3, sb[0].data);
        end else begin
            chk("we_idle", 32'(we), 0);
            chk("a3_idle", 32'(a3), 0);
            chk("wd3_idle", wd3, 0);
        end
        mlook(q_a1, h, d);
        chk("q_hit1", 32'(q_hit1), 32'(h));
        chk("q_data1", q_data1, d);
        mlook(q_a2, h, d);
        chk("q_hit2", 32'(q_hit2), 32'(h));
        chk("q_data2", q_data2, d);
    endtask

    // Called with clk low and inputs driven; advances the model and the DUT by one edge.
    task automatic tick(output bit acc);
        bit rdy;
        #1;
        check_outputs();
        rdy = (DEPTH - sb.size()) >= 2;
        if (sb.size() > 0) void'(sb.pop_front());
        if (rdy) begin
            if (l_valid && l_rd != 5'd0) sb.push_back('{l_rd, l_data});
            if (a_valid && a_rd != 5'd0) sb.push_back('{a_rd, a_data});
        end
        acc = rdy;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input vec_t v);
        l_valid = v.lv; l_rd = v.lrd; l_data = v.ld;
        a_valid = v.av; a_rd = v.ard; a_data = v.ad;
        q_a1 = v.qa1;   q_a2 = v.qa2;
    endtask

    // Producer holds the vector until the queue accepts it
    task automatic apply(input vec_t v);
        bit acc;
        bit done = 0;
        drive(v);
        for (int n = 0; n < 8 && !done; n++) begin
            tick(acc);
            if (acc || !(v.lv || v.av)) done = 1;
        end
        if (!done) chk("accept_timeout", 0, 1);
    endtask

    task automatic idle(input int n, input logic [4:0] qa1, input logic [4:0] qa2);
        bit acc;
        drive('{0, 5'd0, 32'd0, 0, 5'd0, 32'd0, qa1, qa2});
        repeat (n) tick(acc);
    endtask

    vec_t tbl[10];

    initial begin
        bit acc;
        // backpressure: three dual pushes back to back
        tbl[0] = '{1, 5'd1, 32'h101, 1, 5'd2, 32'h202, 5'd1, 5'd2};
        tbl[1] = '{1, 5'd3, 32'h303, 1, 5'd4, 32'h404, 5'd3, 5'd4};
        tbl[2] = '{1, 5'd5, 32'h505, 1, 5'd6, 32'h606, 5'd5, 5'd6};
        // wrap/priority: alternating rd 7/9 across pointer wrap
        for (int i = 0; i < 5; i++)
            tbl[3+i] = '{1, 5'd7, 32'h7000 + 32'(i), 1, 5'd9, 32'h9000 + 32'(i), 5'd7, 5'd9};
        // single-port pushes, one with x0 on the L side
        tbl[8] = '{0, 5'd0, 32'h0, 1, 5'd12, 32'hC0C0, 5'd12, 5'd0};
        tbl[9] = '{1, 5'd0, 32'hBEEF, 1, 5'd13, 32'hD0D0, 5'd13, 5'd12};

        l_valid = 1'b1; l_rd = 5'd5; l_data = 32'h55;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_we", 32'(we), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        l_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // dual push to the same rd: L older, A younger
        drive('{1, 5'd5, 32'h11, 1, 5'd5, 32'h22, 5'd5, 5'd0});
        tick(acc);
        drive('{0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd5, 5'd0});
        #1;
        chk("dual_count", 32'(count), 2);
        chk("dual_qdata_both", q_data1, 32'h22);
        chk("dual_a3_first", 32'(a3), 5);
        chk("dual_wd3_first", wd3, 32'h11);
        tick(acc);
        #1;
        chk("dual_qdata_one", q_data1, 32'h22);
        chk("dual_wd3_second", wd3, 32'h22);
        idle(2, 5'd5, 5'd0);

        // x0 drop
        drive('{1, 5'd3, 32'h7, 1, 5'd0, 32'hDEAD, 5'd0, 5'd3});
        tick(acc);
        drive('{0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd0, 5'd3});
        #1;
        chk("x0_count", 32'(count), 1);
        chk("x0_hit1", 32'(q_hit1), 0);
        chk("x0_a3", 32'(a3), 3);
        idle(2, 5'd0, 5'd0);

        foreach (tbl[i]) apply(tbl[i]);
        idle(6, 5'd7, 5'd9);

        // reset while three entries are queued
        apply('{1, 5'd20, 32'hA0, 1, 5'd21, 32'hA1, 5'd20, 5'd21});
        apply('{1, 5'd22, 32'hA2, 1, 5'd23, 32'hA3, 5'd22, 5'd23});
        drive('{0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd22, 5'd23});
        #1;
        chk("pre_rst_count", 32'(count), 3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we", 32'(we), 0);
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_hit", 32'(q_hit1), 0);
        sb.delete();
        #1 rst_n = 1'b1;
        @(negedge clk);
        idle(3, 5'd22, 5'd23);

        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
